// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: single-cycle ALU with an iterative radix-2 multiply/divide unit.
// Results are registered; o_valid strobes for exactly one cycle in DONE.
module alu_mdu_iter #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [4:0]      i_alu_op,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   input  logic            i_flush,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result
);

   localparam int CNT_W = SHW + 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_SLL  = 5'd2;
   localparam logic [4:0] OP_SLT  = 5'd3;
   localparam logic [4:0] OP_SLTU = 5'd4;
   localparam logic [4:0] OP_XOR  = 5'd5;
   localparam logic [4:0] OP_SRL  = 5'd6;
   localparam logic [4:0] OP_SRA  = 5'd7;
   localparam logic [4:0] OP_OR   = 5'd8;
   localparam logic [4:0] OP_AND  = 5'd9;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   mcand;
   logic [XLEN-1:0]   divisor;
   logic [XLEN-1:0]   quot;
   logic [XLEN-1:0]   remr;
   logic              neg_q;
   logic              rneg_q;
   logic              sel_q;

   logic [SHW-1:0]    shamt;
   logic [XLEN-1:0]   alu_res;
   logic              is_mul, is_div, div_s;
   logic              sgn_a, sgn_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div_zero, div_ovf, div_special;
   logic [XLEN-1:0]   special_res;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] acc_nxt, prod;
   logic [XLEN-1:0]   mul_res;
   logic [XLEN:0]     trial, diff;
   logic [XLEN-1:0]   rem_nxt, quot_nxt, q_fin, r_fin, div_res;

   assign shamt = i_op_b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (i_alu_op)
         OP_ADD:  alu_res = i_op_a + i_op_b;
         OP_SUB:  alu_res = i_op_a - i_op_b;
         OP_SLL:  alu_res = i_op_a << shamt;
         OP_SLT:  alu_res[0] = $signed(i_op_a) < $signed(i_op_b);
         OP_SLTU: alu_res[0] = i_op_a < i_op_b;
         OP_XOR:  alu_res = i_op_a ^ i_op_b;
         OP_SRL:  alu_res = i_op_a >> shamt;
         OP_SRA:  alu_res = $signed(i_op_a) >>> shamt;
         OP_OR:   alu_res = i_op_a | i_op_b;
         OP_AND:  alu_res = i_op_a & i_op_b;
         default: alu_res = '0;
      endcase
   end

   // Operand signedness: MUL/MULH signed*signed, MULHSU signed*unsigned,
   // MULHU unsigned; DIV/REM signed, DIVU/REMU unsigned (opcode bit 0).
   always_comb begin
      is_mul      = i_alu_op[4:2] == 3'b100;
      is_div      = i_alu_op[4:2] == 3'b101;
      div_s       = !i_alu_op[0];
      sgn_a       = i_op_a[XLEN-1] & (is_mul ? (i_alu_op[1:0] != 2'b11) : div_s);
      sgn_b       = i_op_b[XLEN-1] & (is_mul ? !i_alu_op[1] : div_s);
      mag_a       = sgn_a ? -i_op_a : i_op_a;
      mag_b       = sgn_b ? -i_op_b : i_op_b;
      div_zero    = i_op_b == '0;
      div_ovf     = div_s && (i_op_a == MOST_NEG) && (i_op_b == '1);
      div_special = is_div && (div_zero || div_ovf);
      if (div_zero)
         special_res = i_alu_op[1] ? i_op_a : '1;
      else
         special_res = i_alu_op[1] ? '0 : i_op_a;
   end

   // Shift-add step: the carry out of the high half lands in the top bit as
   // the accumulator shifts right, so no extra accumulator bit is needed.
   always_comb begin
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mcand : {XLEN{1'b0}})};
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
      prod    = neg_q ? -acc_nxt : acc_nxt;
      mul_res = sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
   end

   always_comb begin
      trial    = {remr, quot[XLEN-1]};
      diff     = trial - {1'b0, divisor};
      rem_nxt  = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
      quot_nxt = {quot[XLEN-2:0], !diff[XLEN]};
      q_fin    = neg_q ? -quot_nxt : quot_nxt;
      r_fin    = rneg_q ? -rem_nxt : rem_nxt;
      div_res  = sel_q ? r_fin : q_fin;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         divisor  <= '0;
         quot     <= '0;
         remr     <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         sel_q    <= 1'b0;
         o_valid  <= 1'b0;
         o_ready  <= 1'b1;
         o_result <= '0;
      end else if (i_flush) begin
         state   <= IDLE;
         cnt     <= '0;
         o_valid <= 1'b0;
         o_ready <= 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_ready <= 1'b1;
               if (i_valid) begin
                  if (is_mul) begin
                     state   <= MUL;
                     cnt     <= CNT_W'(XLEN);
                     acc     <= {{XLEN{1'b0}}, mag_b};
                     mcand   <= mag_a;
                     neg_q   <= sgn_a ^ sgn_b;
                     sel_q   <= i_alu_op[1:0] != 2'b00;
                     o_ready <= 1'b0;
                  end else if (is_div && !div_special) begin
                     state   <= DIV;
                     cnt     <= CNT_W'(XLEN);
                     divisor <= mag_b;
                     quot    <= mag_a;
                     remr    <= '0;
                     neg_q   <= sgn_a ^ sgn_b;
                     rneg_q  <= sgn_a;
                     sel_q   <= i_alu_op[1];
                     o_ready <= 1'b0;
                  end else begin
                     state    <= DONE;
                     o_valid  <= 1'b1;
                     o_result <= is_div ? special_res : alu_res;
                  end
               end
            end
            MUL: begin
               cnt <= cnt - CNT_W'(1);
               acc <= acc_nxt;
               if (cnt == CNT_W'(1)) begin
                  state    <= DONE;
                  o_valid  <= 1'b1;
                  o_ready  <= 1'b1;
                  o_result <= mul_res;
               end
            end
            DIV: begin
               cnt  <= cnt - CNT_W'(1);
               quot <= quot_nxt;
               remr <= rem_nxt;
               if (cnt == CNT_W'(1)) begin
                  state    <= DONE;
                  o_valid  <= 1'b1;
                  o_ready  <= 1'b1;
                  o_result <= div_res;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mdu_iter.sv
// Bench for alu_mdu_iter (XLEN=32): directed cases plus randomized traffic
// checked every cycle against a cycle-level behavioural model.
module tb_alu_mdu_iter;

   localparam int XLEN = 32;

   logic            i_clk = 1'b0;
   logic            i_reset = 1'b1;
   logic            i_valid = 1'b0;
   logic            o_ready;
   logic [4:0]      i_alu_op = '0;
   logic [XLEN-1:0] i_op_a = '0;
   logic [XLEN-1:0] i_op_b = '0;
   logic            i_flush = 1'b0;
   logic            o_valid;
   logic [XLEN-1:0] o_result;

   int n_checks = 0;
   int n_fail   = 0;

   alu_mdu_iter #(.XLEN(XLEN)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_alu_op(i_alu_op), .i_op_a(i_op_a), .i_op_b(i_op_b), .i_flush(i_flush),
      .o_valid(o_valid), .o_result(o_result)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Reference results straight from the opcode definitions, using wide math.
   function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, za, zb, p;
      int ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      za = {32'b0, a};
      zb = {32'b0, b};
      ia = a;
      ib = b;
      p  = '0;
      case (op)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a << b[4:0];
         5'd3:  return {31'b0, ia < ib};
         5'd4:  return {31'b0, a < b};
         5'd5:  return a ^ b;
         5'd6:  return a >> b[4:0];
         5'd7:  return $signed(a) >>> b[4:0];
         5'd8:  return a | b;
         5'd9:  return a & b;
         5'd16: begin p = sa * sb; return p[31:0]; end
         5'd17: begin p = sa * sb; return p[63:32]; end
         5'd18: begin p = sa * zb; return p[63:32]; end
         5'd19: begin p = za * zb; return p[63:32]; end
         5'd20: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(ia / ib);
         end
         5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd22: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         5'd23: return (b == 0) ? a : a % b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit ref_iter(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op >= 16 && op <= 19) return 1'b1;
      if (op >= 20 && op <= 23) begin
         if (b == 0) return 1'b0;
         if ((op == 20 || op == 22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   // Cycle-level model: a busy countdown plus the pending result.
   logic        exp_valid = 1'b0;
   logic        exp_ready = 1'b1;
   logic [31:0] exp_result = '0;
   logic [31:0] pend_res = '0;
   int          remain = 0;

   always @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         exp_valid  <= 1'b0;
         exp_ready  <= 1'b1;
         exp_result <= '0;
         remain     <= 0;
      end else if (i_flush) begin
         exp_valid <= 1'b0;
         exp_ready <= 1'b1;
         remain    <= 0;
      end else if (remain > 0) begin
         exp_valid <= 1'b0;
         remain    <= remain - 1;
         if (remain == 1) begin
            exp_valid  <= 1'b1;
            exp_ready  <= 1'b1;
            exp_result <= pend_res;
         end
      end else begin
         exp_valid <= 1'b0;
         if (i_valid) begin
            if (ref_iter(i_alu_op, i_op_a, i_op_b)) begin
               remain    <= XLEN;
               pend_res  <= ref_op(i_alu_op, i_op_a, i_op_b);
               exp_ready <= 1'b0;
            end else begin
               exp_valid  <= 1'b1;
               exp_result <= ref_op(i_alu_op, i_op_a, i_op_b);
            end
         end
      end
   end

   always @(negedge i_clk) begin
      check("o_valid", 64'(o_valid), 64'(exp_valid));
      check("o_ready", 64'(o_ready), 64'(exp_ready));
      check("o_result", 64'(o_result), 64'(exp_result));
   end

   task automatic step();
      @(negedge i_clk);
      #1;
   endtask

   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat, busy;
      step();
      i_valid = 1'b1; i_alu_op = op; i_op_a = a; i_op_b = b;
      step();
      i_valid = 1'b0;
      lat = 1;
      busy = 0;
      while (!o_valid && lat < 200) begin
         if (!o_ready) busy++;
         step();
         lat++;
      end
      check({name, "_lat"}, 64'(lat), 64'(exp_lat));
      check({name, "_res"}, 64'(o_result), 64'(exp_res));
      check({name, "_busy"}, 64'(busy), (exp_lat == 1) ? 64'd0 : 64'd32);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 6)
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return $urandom % 16;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      // Pin the reference model with hand-computed values.
      check("pin_add", 64'(ref_op(0, 32'h7FFF_FFFF, 32'h1)), 64'h8000_0000);
      check("pin_sra", 64'(ref_op(7, 32'h8000_0000, 32'h24)), 64'hF800_0000);
      check("pin_mul", 64'(ref_op(16, 32'hFFFF_FFFF, 32'h2)), 64'hFFFF_FFFE);
      check("pin_mulh", 64'(ref_op(17, 32'hFFFF_FFFF, 32'h2)), 64'hFFFF_FFFF);
      check("pin_mulhsu", 64'(ref_op(18, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFF);
      check("pin_mulhu", 64'(ref_op(19, 32'hFFFF_FFFF, 32'h2)), 64'h0000_0001);
      check("pin_div", 64'(ref_op(20, 32'hFFFF_FFF9, 32'h2)), 64'hFFFF_FFFD);
      check("pin_rem", 64'(ref_op(22, 32'hFFFF_FFF9, 32'h2)), 64'hFFFF_FFFF);
      check("pin_remu0", 64'(ref_op(23, 32'h7, 32'h0)), 64'h7);
      check("pin_slt", 64'(ref_op(3, 32'hFFFF_FFFF, 32'h1)), 64'h1);

      repeat (3) step();
      check("reset_ready", 64'(o_ready), 64'h1);
      check("reset_result", 64'(o_result), 64'h0);
      i_reset = 1'b0;

      run_op("add",    5'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1);
      run_op("sra",    5'd7,  32'h8000_0000, 32'h24,        32'hF800_0000, 1);
      run_op("mul",    5'd16, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 33);
      run_op("mulh",   5'd17, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 33);
      run_op("mulhu",  5'd19, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 33);
      run_op("div",    5'd20, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33);
      run_op("rem",    5'd22, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33);
      run_op("divu0",  5'd21, 32'h7,         32'h0,         32'hFFFF_FFFF, 1);
      run_op("remu0",  5'd23, 32'h7,         32'h0,         32'h7,         1);
      run_op("divovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("removf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
      run_op("rsvd",   5'd12, 32'h1234_5678, 32'h1,         32'h0,         1);
      run_op("add2",   5'd0,  32'h1,         32'h1,         32'h2,         1);

      // Flush mid-divide: nothing comes out, result register untouched.
      step();
      i_valid = 1'b1; i_alu_op = 5'd21; i_op_a = 32'd100; i_op_b = 32'd7;
      step();
      i_valid = 1'b0;
      repeat (9) step();
      i_flush = 1'b1; i_valid = 1'b1; i_alu_op = 5'd0;
      step();
      i_flush = 1'b0; i_valid = 1'b0;
      check("flush_ready", 64'(o_ready), 64'h1);
      check("flush_valid", 64'(o_valid), 64'h0);
      check("flush_result", 64'(o_result), 64'h2);
      seen = 1'b0;
      repeat (40) begin
         step();
         if (o_valid) seen = 1'b1;
      end
      check("flush_no_valid", 64'(seen), 64'h0);

      // Reset mid-divide, then accept on the first edge after release.
      i_valid = 1'b1; i_alu_op = 5'd21; i_op_a = 32'd100; i_op_b = 32'd7;
      step();
      i_valid = 1'b0;
      repeat (9) step();
      i_reset = 1'b1;
      #1;
      check("rst_async_result", 64'(o_result), 64'h0);
      check("rst_async_ready", 64'(o_ready), 64'h1);
      check("rst_async_valid", 64'(o_valid), 64'h0);
      step();
      i_reset = 1'b0;
      i_valid = 1'b1; i_alu_op = 5'd0; i_op_a = 32'd2; i_op_b = 32'd3;
      step();
      i_valid = 1'b0;
      check("rst_first_valid", 64'(o_valid), 64'h1);
      check("rst_first_result", 64'(o_result), 64'h5);

      // Back-to-back single-cycle ops.
      step();
      i_valid = 1'b1; i_alu_op = 5'd0; i_op_a = 32'h10; i_op_b = 32'h20;
      step();
      i_alu_op = 5'd5; i_op_a = 32'hF0; i_op_b = 32'h0F;
      check("b2b_valid1", 64'(o_valid), 64'h1);
      check("b2b_res1", 64'(o_result), 64'h30);
      step();
      i_valid = 1'b0;
      check("b2b_valid2", 64'(o_valid), 64'h1);
      check("b2b_res2", 64'(o_result), 64'hFF);
      step();
      check("b2b_valid3", 64'(o_valid), 64'h0);

      // Requests during a busy multiply are ignored.
      i_valid = 1'b1; i_alu_op = 5'd16; i_op_a = 32'd3; i_op_b = 32'd5;
      step();
      i_alu_op = 5'd0; i_op_a = 32'd1; i_op_b = 32'd1;
      repeat (5) step();
      i_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (o_valid) seen = 1'b1;
         else step();
      end
      check("busy_ignore_seen", 64'(seen), 64'h1);
      check("busy_ignore_res", 64'(o_result), 64'd15);

      // Randomized traffic; the model compare process does the checking.
      for (int i = 0; i < 3000; i++) begin
         step();
         i_valid = ($urandom % 2) == 1;
         case ($urandom % 3)
            0: i_alu_op = 5'($urandom % 10);
            1: i_alu_op = 5'(16 + $urandom % 8);
            default: i_alu_op = 5'($urandom % 32);
         endcase
         i_op_a  = pick();
         i_op_b  = pick();
         i_flush = ($urandom % 50) == 0;
         i_reset = ($urandom % 300) == 0;
      end
      step();
      i_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
      repeat (40) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mdu_iter.md
ALU_MDU_ITER -- requirements
Module: alu_mdu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width taken from i_op_b[SHW-1:0].
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  operation request.
REQ-006 SHALL have port o_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port i_alu_op  input  5  opcode (see REQ-011).
REQ-008 SHALL have port i_op_a, i_op_b  input  XLEN  operands.
REQ-009 SHALL have port i_flush  input  1  abort in-flight operation.
REQ-010 SHALL have port o_valid  output  1  one-cycle result strobe; port o_result  output  XLEN  registered result.

Function
REQ-011 Opcodes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10-15 reserved (result 0), 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU, 24-31 reserved (result 0).
REQ-012 Accept SHALL occur on a rising edge where i_valid && o_ready && !i_flush; operands and opcode SHALL be captured at accept and not resampled.
REQ-013 FSM states SHALL be IDLE, MUL, DIV, DONE; o_ready SHALL be 1 in IDLE and DONE, 0 in MUL and DIV.
REQ-014 Opcodes 0-15 and division special cases (REQ-019, REQ-020) SHALL go to DONE at the accept edge: o_valid high the cycle after accept (latency 1).
REQ-015 Opcodes 16-19 SHALL go to MUL, 20-23 (non-special) to DIV; each SHALL iterate exactly XLEN cycles using a down-counter of width SHW+1, then enter DONE: o_valid high XLEN+1 cycles after accept.
REQ-016 Multiply SHALL be radix-2 shift-add on operand magnitudes into a 2*XLEN accumulator, sign-corrected at the end; MUL returns low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned interpretation.
REQ-017 Divide SHALL be radix-2 restoring on magnitudes; quotient sign = sign(a) XOR sign(b), remainder sign = sign(a) (truncation toward zero).
REQ-018 Shifts SHALL use i_op_b[SHW-1:0]; SLT/SLTU SHALL return {XLEN-1 zeros, flag}; ADD/SUB wrap modulo 2^XLEN.
REQ-019 Divide by zero: DIV/DIVU quotient SHALL be all ones; REM/REMU SHALL return i_op_a.
REQ-020 Signed overflow (a = most-negative, b = all ones): DIV SHALL return a, REM SHALL return 0.
REQ-021 DONE SHALL last exactly one cycle; next state IDLE, or DONE/MUL/DIV if a new request is accepted in that cycle (back-to-back single-cycle ops give one result per cycle).
REQ-022 o_valid SHALL be high only in DONE; no back-pressure; o_result SHALL update only on entry to DONE and hold until the next DONE entry.
REQ-023 i_flush SHALL force IDLE on the next edge from any state, suppress the pending o_valid, block acceptance that cycle, and leave o_result unchanged; i_flush with i_valid SHALL accept nothing.
REQ-024 i_valid while o_ready=0 SHALL be ignored, with no effect on in-flight operation.

Reset
REQ-025 While i_reset=1, state SHALL be IDLE immediately (asynchronous), counter 0, o_valid=0, o_result=0, o_ready=1.
REQ-026 Reset asserted mid-iteration SHALL discard the operation; no o_valid SHALL follow deassertion.
REQ-027 First accept SHALL be possible on the first rising edge after i_reset deasserts.

Verification (XLEN=32)
REQ-028 ADD a=0x7FFFFFFF b=1 -> o_result 0x80000000, o_valid exactly 1 cycle after accept; SRA a=0x80000000 b=0x24 -> 0xF8000000 (shift 4).
REQ-029 MUL then MULH, a=0xFFFFFFFF b=2 -> 0xFFFFFFFE then 0xFFFFFFFF; MULHU same operands -> 0x00000001; each o_valid 33 cycles after accept, o_ready low 32 cycles.
REQ-030 DIV a=0xFFFFFFF9 (-7) b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF, REMU 7/0 -> 7 (latency 1).
REQ-031 DIV a=0x80000000 b=0xFFFFFFFF -> 0x80000000, REM -> 0, latency 1.
REQ-032 Start DIVU, assert i_flush on iteration 10 -> no o_valid, o_ready=1 next cycle, o_result unchanged; repeat with i_reset instead -> o_result 0.
REQ-033 Back-to-back: ADD accepted in IDLE, XOR accepted in DONE -> two consecutive o_valid cycles with correct results; i_valid during MUL busy ignored.
